// File: rtl/ahbl_apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB3 bridge.
// The ERR1/ERR2 states only exist when AHBL_APB_PSLVERR_EN is defined.
package ahbl_apb_pkg;

  // Bridge FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WLATCH = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4
`ifdef AHBL_APB_PSLVERR_EN
    ,
    ST_ERR1   = 3'd5,
    ST_ERR2   = 3'd6
`endif
  } state_t;

  // AHB transfer types.
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // AHB response codes.
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite slave to APB3 master bridge. Each accepted AHB transfer is
// replayed as one APB read or write; AHB wait states are inserted until the
// APB access completes. All outputs are registered.
// Optional feature: define AHBL_APB_PSLVERR_EN to map PSLVERR onto a
// two-cycle AHB ERROR response; otherwise PSLVERR is ignored and HRESP is OKAY.
module ahbl_apb_bridge
  import ahbl_apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADYIN,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  state_t state;
  logic   accept;

  // A real (NONSEQ/SEQ) transfer addressed to us while the bus is ready.
  assign accept = HSEL & HREADYIN & HTRANS[1];

`ifdef AHBL_APB_PSLVERR_EN
  logic hresp_q;
  assign HRESP = hresp_q;

  // Size is ignored (all accesses are 32-bit); upper address bits are not decoded.
  logic unused;
  assign unused = ^{HSIZE, HTRANS[0], HADDR[31:ADDR_WIDTH]};
`else
  assign HRESP = HRESP_OKAY;

  // Size is ignored (all accesses are 32-bit); upper address bits and
  // PSLVERR are not used in this build.
  logic unused;
  assign unused = ^{HSIZE, HTRANS[0], HADDR[31:ADDR_WIDTH], PSLVERR};
`endif

  // FSM plus datapath registers; every output is set for the state being entered.
  // NOTE: state and outputs use non-blocking assignments so every register
  // samples the pre-edge values and the order of statements does not matter.
  always_ff @(posedge HCLK) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // HRESETN is not in the sensitivity list.
    if (!HRESETN) begin
      state     <= ST_IDLE;
      HREADYOUT <= 1'b1;
      HRDATA    <= '0;
      PADDR     <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
`ifdef AHBL_APB_PSLVERR_EN
      hresp_q   <= HRESP_OKAY;
`endif
    end else begin
      case (state)
        ST_WLATCH: begin
          PWDATA <= HWDATA;
          PSEL   <= 1'b1;
          state  <= ST_SETUP;
        end

        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end

        ST_ACCESS: begin
          // Without PREADY everything holds: one more wait state.
          if (PREADY) begin
            if (!PWRITE) HRDATA <= PRDATA;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
`ifdef AHBL_APB_PSLVERR_EN
            if (PSLVERR) begin
              hresp_q <= HRESP_ERROR;
              state   <= ST_ERR1;
            end else begin
              HREADYOUT <= 1'b1;
              state     <= ST_DONE;
            end
`else
            HREADYOUT <= 1'b1;
            state     <= ST_DONE;
`endif
          end
        end

`ifdef AHBL_APB_PSLVERR_EN
        ST_ERR1: begin
          // Second cycle of the ERROR response: HRESP stays high, ready rises.
          HREADYOUT <= 1'b1;
          state     <= ST_ERR2;
        end
`endif

        default: begin
          // IDLE, DONE and ERR2 all behave as an address phase slot.
`ifdef AHBL_APB_PSLVERR_EN
          hresp_q <= HRESP_OKAY;
`endif
          if (accept) begin
            PADDR     <= HADDR[ADDR_WIDTH-1:0];
            PWRITE    <= HWRITE;
            HREADYOUT <= 1'b0;
            if (HWRITE) begin
              state <= ST_WLATCH;
            end else begin
              PSEL  <= 1'b1;
              state <= ST_SETUP;
            end
          end else begin
            HREADYOUT <= 1'b1;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// Self-checking bench for ahbl_apb_bridge: a directed vector table, a few
// hand-written multi-cycle sequences and a randomized run scored against a
// transaction-level model (peripheral memory image plus last-read register).
module tb_ahbl_apb_bridge;
  import ahbl_apb_pkg::*;

  localparam int AW = 12;
`ifdef AHBL_APB_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int E = ERR_EN ? 1 : 0;

  logic          HCLK = 1'b0;
  logic          HRESETN;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA;
  logic          HREADYIN;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [31:0]   PWDATA;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  // Single-slave system: the bus-level HREADY is the bridge's own ready.
  assign HREADYIN = HREADYOUT;

  always #5 HCLK = ~HCLK;

  ahbl_apb_bridge #(.ADDR_WIDTH(AW)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADYIN(HREADYIN), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .HRDATA(HRDATA), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  // ---------------- APB peripheral (16-word register file) ----------------
  int          cur_waits;
  bit          cur_err;
  int          wait_cnt;
  logic [31:0] slv_mem [16];
  int          psel_cyc;
  int          pen_cyc;

  // Responder: inserts cur_waits wait states, then completes with cur_err.
  always @(negedge HCLK) begin
    if (PSEL === 1'b1 && PENABLE === 1'b1) begin
      if (wait_cnt < cur_waits) begin
        PREADY   <= 1'b0;
        wait_cnt <= wait_cnt + 1;
        PSLVERR  <= 1'($urandom_range(0, 1));
        PRDATA   <= $urandom;
      end else begin
        PREADY   <= 1'b1;
        PSLVERR  <= cur_err;
        PRDATA   <= slv_mem[PADDR[5:2]];
      end
    end else begin
      PREADY   <= 1'($urandom_range(0, 1));
      PSLVERR  <= 1'($urandom_range(0, 1));
      PRDATA   <= $urandom;
      wait_cnt <= 0;
    end
  end

  // Peripheral storage and APB activity counters.
  always @(posedge HCLK) begin
    if (HRESETN !== 1'b1) begin
      for (int i = 0; i < 16; i++) slv_mem[i] <= 32'h1000_0000 + i;
    end else if (PSEL === 1'b1 && PENABLE === 1'b1 && PREADY === 1'b1 && PWRITE === 1'b1) begin
      slv_mem[PADDR[5:2]] <= PWDATA;
    end
    if (PSEL === 1'b1)    psel_cyc <= psel_cyc + 1;
    if (PENABLE === 1'b1) pen_cyc  <= pen_cyc + 1;
  end

  // ---------------- Reference model ----------------
  logic [31:0] ref_mem [16];
  logic [31:0] ref_hrdata;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h1000_0000 + i;
    ref_hrdata = 32'h0;
  endfunction

  function automatic void model_apply(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    logic [3:0] idx;
    idx = addr[5:2];
    if (wr) ref_mem[idx] = wdata;
    else    ref_hrdata   = ref_mem[idx];
  endfunction

  // ---------------- Checking ----------------
  int n_cmp;
  int n_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- AHB master ----------------
  // Called at a negedge: present the address phase, let edge A accept it,
  // then drive the data phase at the following negedge (cycle A+1).
  task automatic ahb_start(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    HSEL   = 1'b1;
    HTRANS = HTRANS_NONSEQ;
    HADDR  = addr;
    HWRITE = wr;
    HSIZE  = 3'($urandom_range(0, 2));
    @(posedge HCLK);
    @(negedge HCLK);
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
    HADDR  = $urandom;
    HWRITE = 1'($urandom_range(0, 1));
    HWDATA = wdata;
  endtask

  // Waits (bounded) for HREADYOUT, checking the APB side while PSEL is high.
  // Returns wait states counted from edge A, number of HRESP-high cycles and
  // HRESP in the completion cycle.
  task automatic ahb_finish(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output int ws, output int resp_cyc, output logic resp_last);
    int n;
    logic [31:0] exp_pa;
    exp_pa   = {20'h0, addr[AW-1:0]};
    n        = 1;
    resp_cyc = 0;
    while (HREADYOUT !== 1'b1 && n < 64) begin
      if (HRESP === HRESP_ERROR) resp_cyc++;
      if (PSEL === 1'b1) begin
        check("paddr", {20'h0, PADDR}, exp_pa);
        check("pwrite", {31'h0, PWRITE}, {31'h0, wr});
        if (wr) check("pwdata", PWDATA, wdata);
      end
      @(posedge HCLK);
      @(negedge HCLK);
      n++;
    end
    if (HREADYOUT !== 1'b1) check("ready_timeout", {31'h0, HREADYOUT}, 32'h1);
    if (HRESP === HRESP_ERROR) resp_cyc++;
    resp_last = HRESP;
    ws = n - 1;
  endtask

  // One complete transfer starting from an idle bus, with full response checks.
  task automatic run_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input bit err,
                          input int exp_ws, input logic [31:0] exp_rd);
    int   ws;
    int   rc;
    logic rl;
    int   p0;
    int   e0;
    bit   exp_err;
    exp_err   = err & ERR_EN;
    cur_waits = waits;
    cur_err   = err;
    @(negedge HCLK);
    p0 = psel_cyc;
    e0 = pen_cyc;
    ahb_start(wr, addr, wdata);
    ahb_finish(wr, addr, wdata, ws, rc, rl);
    check("wait_states", ws, exp_ws);
    check("hrdata", HRDATA, exp_rd);
    check("hresp_last", {31'h0, rl}, {31'h0, exp_err});
    check("hresp_cycles", rc, exp_err ? 2 : 0);
    check("penable_cycles", pen_cyc - e0, waits + 1);
    check("psel_cycles", psel_cyc - p0, waits + 2);
    cur_err = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    bit          err;
    logic [31:0] exp_rd;
    int          exp_ws;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int          ws;
    int          rc;
    logic        rl;
    int          p0;
    logic [31:0] r;
    logic [3:0]  idx;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          wr;
    int          w;
    bit          err;

    // {wr, addr, wdata, waits, err, expected HRDATA, expected wait states}
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hA5A5_1234, 0, 1'b0, 32'h0000_0000, 3};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         0, 1'b0, 32'hA5A5_1234, 2};
    vecs[2] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 3, 1'b0, 32'hA5A5_1234, 6};
    vecs[3] = '{1'b0, 32'h0000_0004, 32'h0,         1, 1'b0, 32'hDEAD_BEEF, 3};
    vecs[4] = '{1'b0, 32'hFFFF_F03C, 32'h0,         0, 1'b0, 32'h1000_000F, 2};
    vecs[5] = '{1'b0, 32'h0000_0008, 32'h0,         0, 1'b1, 32'h1000_0002, 2 + E};
    vecs[6] = '{1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, 2, 1'b1, 32'h1000_0002, 5 + E};
    vecs[7] = '{1'b0, 32'h0000_0FFC, 32'h0,         0, 1'b0, 32'h0BAD_F00D, 2};

    n_cmp     = 0;
    n_mis     = 0;
    HRESETN   = 1'b0;
    HSEL      = 1'b0;
    HADDR     = 32'h0;
    HTRANS    = HTRANS_IDLE;
    HWRITE    = 1'b0;
    HSIZE     = 3'b010;
    HWDATA    = 32'h0;
    cur_waits = 0;
    cur_err   = 1'b0;
    model_reset();

    // Reset values.
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    check("rst_hresp", {31'h0, HRESP}, 32'h0);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_psel", {31'h0, PSEL}, 32'h0);
    check("rst_penable", {31'h0, PENABLE}, 32'h0);
    check("rst_pwrite", {31'h0, PWRITE}, 32'h0);
    check("rst_paddr", {20'h0, PADDR}, 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    HRESETN = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      run_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].err,
               vecs[i].exp_ws, vecs[i].exp_rd);
      model_apply(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
    end

    // Back-to-back write then read, second address accepted in DONE.
    cur_waits = 0;
    @(negedge HCLK);
    ahb_start(1'b1, 32'h0000_0020, 32'h1234_5678);
    ahb_finish(1'b1, 32'h0000_0020, 32'h1234_5678, ws, rc, rl);
    check("b2b_wr_ws", ws, 3);
    check("b2b_done_psel", {31'h0, PSEL}, 32'h0);
    model_apply(1'b1, 32'h0000_0020, 32'h1234_5678);
    ahb_start(1'b0, 32'h0000_0020, 32'h0);
    check("b2b_setup_psel", {31'h0, PSEL}, 32'h1);
    check("b2b_setup_penable", {31'h0, PENABLE}, 32'h0);
    ahb_finish(1'b0, 32'h0000_0020, 32'h0, ws, rc, rl);
    model_apply(1'b0, 32'h0000_0020, 32'h0);
    check("b2b_rd_ws", ws, 2);
    check("b2b_rd_hrdata", HRDATA, ref_hrdata);

    // IDLE/BUSY transfers and deselected NONSEQ never reach the APB side.
    @(negedge HCLK);
    p0     = psel_cyc;
    HSEL   = 1'b1;
    HTRANS = HTRANS_IDLE;
    HADDR  = 32'h0000_0010;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) HTRANS = HTRANS_BUSY;
      if (i == 4) begin
        HSEL   = 1'b0;
        HTRANS = HTRANS_NONSEQ;
      end
      @(posedge HCLK);
      @(negedge HCLK);
      check("noxfer_psel", {31'h0, PSEL}, 32'h0);
      check("noxfer_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    end
    HSEL   = 1'b0;
    HTRANS = HTRANS_IDLE;
    @(posedge HCLK);
    @(negedge HCLK);
    check("noxfer_psel_cycles", psel_cyc - p0, 0);

    // Randomized transfers against the model.
    for (int i = 0; i < 60; i++) begin
      r     = $urandom;
      idx   = 4'($urandom_range(0, 15));
      addr  = {r[31:6], idx, 2'b00};
      wdata = $urandom;
      wr    = 1'($urandom_range(0, 1));
      w     = $urandom_range(0, 3);
      err   = ($urandom_range(0, 3) == 0);
      run_xfer(wr, addr, wdata, w, err,
               (wr ? 3 : 2) + w + (err ? E : 0),
               wr ? ref_hrdata : ref_mem[idx]);
      model_apply(wr, addr, wdata);
    end

    // Reset asserted during ACCESS drops the transfer.
    cur_waits = 6;
    @(negedge HCLK);
    ahb_start(1'b0, 32'h0000_0010, 32'h0);
    @(posedge HCLK);
    @(negedge HCLK);
    check("pre_rst_penable", {31'h0, PENABLE}, 32'h1);
    HRESETN = 1'b0;
    @(posedge HCLK);
    @(negedge HCLK);
    check("midrst_psel", {31'h0, PSEL}, 32'h0);
    check("midrst_penable", {31'h0, PENABLE}, 32'h0);
    check("midrst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    check("midrst_hresp", {31'h0, HRESP}, 32'h0);
    check("midrst_hrdata", HRDATA, 32'h0);
    model_reset();
    HRESETN = 1'b1;
    run_xfer(1'b0, 32'h0000_0010, 32'h0, 0, 1'b0, 2, ref_mem[4]);
    model_apply(1'b0, 32'h0000_0010, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
